local_injector: RTL

LOCAL_INJECTOR -- requirements
Module: local_injector

---
 rtl/local_injector.sv | 113 +++++++++++
 1 files changed

// File: rtl/local_injector.sv
// Local-port packet injector: serialises one header flit and PKT_FLITS-1 payload
// flits into the router's local input, paced by credit-based flow control.
module local_injector #(
    parameter int BUF_DEPTH = 8,
    parameter int PKT_FLITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [15:0]                  pkt_dest_i,
    input  logic [16*(PKT_FLITS-1)-1:0]  pkt_payload_i,
    output logic [15:0]                  flit_data_o,
    output logic                         flit_valid_o,
    input  logic                         credit_i,
    output logic [3:0]                   credits_o,
    output logic                         busy_o,
    output logic                         credit_err_o
);

    localparam int                IDX_W    = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_FLITS - 1);
    localparam logic [3:0]        CRED_MAX = 4'(BUF_DEPTH);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [3:0]                     credits_q, credits_d;
    logic                           flit_valid_q, flit_valid_d;
    logic [15:0]                    flit_data_q, flit_data_d;
    logic                           err_q, err_d;
    logic [15:0]                    dest_q, dest_d;
    logic [16*(PKT_FLITS-1)-1:0]    payload_q, payload_d;

    logic [PKT_FLITS-1:0][15:0]     flits;
    logic                           issue;

    // Flit 0 is the header; flit i is payload slice i-1.
    assign flits = {payload_q, dest_q};

    // A credit arriving this cycle is not counted until the next edge.
    assign issue = (state_q == SEND) && (credits_q != 4'd0);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dest_d       = dest_q;
        payload_d    = payload_q;
        flit_data_d  = flit_data_q;
        flit_valid_d = issue;
        credits_d    = credits_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (pkt_valid_i) begin
                    dest_d    = pkt_dest_i;
                    payload_d = pkt_payload_i;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (issue) begin
                    flit_data_d = flits[idx_q];
                    idx_d       = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case ({issue, credit_i})
            2'b10:   credits_d = credits_q - 4'd1;
            2'b01: begin
                if (credits_q == CRED_MAX) err_d = 1'b1;
                else                       credits_d = credits_q + 4'd1;
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            credits_q    <= CRED_MAX;
            flit_valid_q <= 1'b0;
            flit_data_q  <= 16'h0000;
            err_q        <= 1'b0;
            dest_q       <= 16'h0000;
            payload_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            credits_q    <= credits_d;
            flit_valid_q <= flit_valid_d;
            flit_data_q  <= flit_data_d;
            err_q        <= err_d;
            dest_q       <= dest_d;
            payload_q    <= payload_d;
        end
    end

    assign pkt_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q == SEND);
    assign flit_valid_o = flit_valid_q;
    assign flit_data_o  = flit_data_q;
    assign credits_o    = credits_q;
    assign credit_err_o = err_q;

endmodule
